// File: rtl/atm_keypad_tx.sv
// Keypad/card front-end for the ATM controller: turns raw key events into the
// ATM's card/PIN/transaction/amount strobes and follows the ATM result outputs.
module atm_keypad_tx #(
    parameter int AMT_W      = 32,
    parameter int MAX_DIGITS = 9,
    parameter int PIN_DIGITS = 4,
    parameter int RESP_WAIT  = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_card_in,
    input  logic             i_key_valid,
    input  logic [3:0]       i_key_code,
    input  logic             i_pin_incorrecto,
    input  logic             i_bloqueo,
    input  logic             i_balance_actualizado,
    input  logic             i_fondos_insuficientes,
    output logic             o_tarjeta_recibida,
    output logic [3:0]       o_digito,
    output logic             o_digito_stb,
    output logic             o_tipo_trans,
    output logic [AMT_W-1:0] o_monto,
    output logic             o_monto_stb,
    output logic             o_busy
);

    localparam int PC_W = $clog2(PIN_DIGITS + 1);
    localparam int WC_W = $clog2(RESP_WAIT + 1);
    localparam int DC_W = $clog2(MAX_DIGITS + 1);
    localparam int EXT_W = AMT_W + 4;

    localparam logic [3:0] K_ENTER = 4'hA;
    localparam logic [3:0] K_CLEAR = 4'hB;
    localparam logic [3:0] K_RET   = 4'hC;
    localparam logic [3:0] K_DEP   = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE, S_PIN, S_PIN_WAIT, S_SELECT, S_AMOUNT, S_RESULT, S_DONE, S_LOCKED
    } state_t;

    state_t            r_state, w_state;
    logic              r_card_q, r_pinc_q, r_bal_q, r_fon_q;
    logic [PC_W-1:0]   r_pin_cnt, w_pin_cnt;
    logic [WC_W-1:0]   r_wait_cnt, w_wait_cnt;
    logic [DC_W-1:0]   r_dcnt, w_dcnt;
    logic [AMT_W-1:0]  r_acc, w_acc;
    logic              r_tarjeta, w_tarjeta;
    logic [3:0]        r_digito, w_digito;
    logic              r_digito_stb, w_digito_stb;
    logic              r_tipo, w_tipo;
    logic [AMT_W-1:0]  r_monto, w_monto;
    logic              r_monto_stb, w_monto_stb;

    logic              w_card_rise, w_card_fall, w_pinc_rise, w_result_rise;
    logic              w_is_digit;
    logic [EXT_W-1:0]  w_acc_mul;

    assign w_card_rise   = i_card_in & ~r_card_q;
    assign w_card_fall   = ~i_card_in & r_card_q;
    assign w_pinc_rise   = i_pin_incorrecto & ~r_pinc_q;
    assign w_result_rise = (i_balance_actualizado & ~r_bal_q) |
                           (i_fondos_insuficientes & ~r_fon_q);
    assign w_is_digit    = i_key_valid && (i_key_code <= 4'd9);
    // Widened so acc*10+d cannot wrap before truncation back to AMT_W.
    assign w_acc_mul     = EXT_W'(r_acc) * EXT_W'(10) + EXT_W'(i_key_code);

    always_comb begin
        w_state      = r_state;
        w_pin_cnt    = r_pin_cnt;
        w_wait_cnt   = r_wait_cnt;
        w_dcnt       = r_dcnt;
        w_acc        = r_acc;
        w_tarjeta    = 1'b0;
        w_digito     = r_digito;
        w_digito_stb = 1'b0;
        w_tipo       = r_tipo;
        w_monto      = r_monto;
        w_monto_stb  = 1'b0;

        if (w_card_fall && r_state != S_IDLE && r_state != S_LOCKED) begin
            w_state    = S_IDLE;
            w_pin_cnt  = '0;
            w_wait_cnt = '0;
            w_dcnt     = '0;
            w_acc      = '0;
            w_tipo     = 1'b0;
            w_monto    = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_pin_cnt = '0;
                    if (w_card_rise) begin
                        w_tarjeta = 1'b1;
                        w_state   = S_PIN;
                    end
                end
                S_PIN: begin
                    if (w_is_digit) begin
                        w_digito     = i_key_code;
                        w_digito_stb = 1'b1;
                        if (r_pin_cnt == PC_W'(PIN_DIGITS - 1)) begin
                            w_pin_cnt  = '0;
                            w_wait_cnt = '0;
                            w_state    = S_PIN_WAIT;
                        end else begin
                            w_pin_cnt = r_pin_cnt + 1'b1;
                        end
                    end
                end
                S_PIN_WAIT: begin
                    if (i_bloqueo)
                        w_state = S_LOCKED;
                    else if (w_pinc_rise)
                        w_state = S_PIN;
                    else if (r_wait_cnt == WC_W'(RESP_WAIT - 1))
                        w_state = S_SELECT;
                    else
                        w_wait_cnt = r_wait_cnt + 1'b1;
                end
                S_SELECT: begin
                    if (i_key_valid && (i_key_code == K_RET || i_key_code == K_DEP)) begin
                        w_tipo  = (i_key_code == K_RET);
                        w_acc   = '0;
                        w_dcnt  = '0;
                        w_state = S_AMOUNT;
                    end
                end
                S_AMOUNT: begin
                    if (w_is_digit) begin
                        if (r_dcnt < DC_W'(MAX_DIGITS)) begin
                            w_acc  = w_acc_mul[AMT_W-1:0];
                            w_dcnt = r_dcnt + 1'b1;
                        end
                    end else if (i_key_valid && i_key_code == K_CLEAR) begin
                        w_acc  = '0;
                        w_dcnt = '0;
                    end else if (i_key_valid && i_key_code == K_ENTER && r_dcnt != '0) begin
                        w_monto     = r_acc;
                        w_monto_stb = 1'b1;
                        w_state     = S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (w_result_rise)
                        w_state = S_DONE;
                end
                S_DONE: begin
                    if (!i_card_in) begin
                        w_state = S_IDLE;
                        w_tipo  = 1'b0;
                        w_monto = '0;
                    end
                end
                S_LOCKED: ;
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_card_q     <= 1'b0;
            r_pinc_q     <= 1'b0;
            r_bal_q      <= 1'b0;
            r_fon_q      <= 1'b0;
            r_pin_cnt    <= '0;
            r_wait_cnt   <= '0;
            r_dcnt       <= '0;
            r_acc        <= '0;
            r_tarjeta    <= 1'b0;
            r_digito     <= '0;
            r_digito_stb <= 1'b0;
            r_tipo       <= 1'b0;
            r_monto      <= '0;
            r_monto_stb  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_card_q     <= i_card_in;
            r_pinc_q     <= i_pin_incorrecto;
            r_bal_q      <= i_balance_actualizado;
            r_fon_q      <= i_fondos_insuficientes;
            r_pin_cnt    <= w_pin_cnt;
            r_wait_cnt   <= w_wait_cnt;
            r_dcnt       <= w_dcnt;
            r_acc        <= w_acc;
            r_tarjeta    <= w_tarjeta;
            r_digito     <= w_digito;
            r_digito_stb <= w_digito_stb;
            r_tipo       <= w_tipo;
            r_monto      <= w_monto;
            r_monto_stb  <= w_monto_stb;
        end
    end

    assign o_tarjeta_recibida = r_tarjeta;
    assign o_digito           = r_digito;
    assign o_digito_stb       = r_digito_stb;
    assign o_tipo_trans       = r_tipo;
    assign o_monto            = r_monto;
    assign o_monto_stb        = r_monto_stb;
    assign o_busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_atm_keypad_tx.sv
// Bench for atm_keypad_tx: directed session scenarios plus randomized sessions
// checked against an arithmetic model of PIN forwarding and amount entry.
module tb_atm_keypad_tx;

    localparam int AMT_W = 32;

    logic             clk = 1'b0;
    logic             reset, card_in, key_valid, pin_inc, bloqueo, bal, fondos;
    logic [3:0]       key_code;
    logic             tarjeta, digito_stb, tipo, monto_stb, busy;
    logic [3:0]       digito;
    logic [AMT_W-1:0] monto;

    int checks = 0;
    int failures = 0;

    int n_tar = 0, n_dig = 0, n_mon = 0, n_multi = 0;
    logic [3:0] q_dig[$];

    atm_keypad_tx #(.AMT_W(AMT_W), .MAX_DIGITS(9), .PIN_DIGITS(4), .RESP_WAIT(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_card_in(card_in), .i_key_valid(key_valid),
        .i_key_code(key_code), .i_pin_incorrecto(pin_inc), .i_bloqueo(bloqueo),
        .i_balance_actualizado(bal), .i_fondos_insuficientes(fondos),
        .o_tarjeta_recibida(tarjeta), .o_digito(digito), .o_digito_stb(digito_stb),
        .o_tipo_trans(tipo), .o_monto(monto), .o_monto_stb(monto_stb), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            n_tar <= n_tar + int'(tarjeta);
            n_dig <= n_dig + int'(digito_stb);
            n_mon <= n_mon + int'(monto_stb);
            if ((int'(tarjeta) + int'(digito_stb) + int'(monto_stb)) > 1) n_multi <= n_multi + 1;
            if (digito_stb) q_dig.push_back(digito);
        end
    end

    // All stimulus changes 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        step();
        key_valid = 1'b0;
    endtask

    task automatic go_to_amount(input logic [3:0] sel);
        card_in = 1'b1;
        step();
        for (int i = 0; i < 4; i++) press(4'(i));
        repeat (4) step();
        press(sel);
    endtask

    task automatic end_session(input logic use_bal);
        if (use_bal) bal = 1'b1; else fondos = 1'b1;
        step();
        bal = 1'b0;
        fondos = 1'b0;
        card_in = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({tarjeta, digito_stb, tipo, monto_stb, busy, digito, monto} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h want=0", {tarjeta, digito_stb, tipo, monto_stb, busy, digito, monto});
        end
        reset = 1'b0;
        press(4'd5);
        checks++;
        if (busy !== 1'b0 || digito_stb !== 1'b0) begin
            failures++;
            $display("FAIL idle_keys_ignored got=busy%0b stb%0b want=0 0", busy, digito_stb);
        end
    endtask

    task automatic test_card_and_pin();
        int d0;
        d0 = n_dig;
        card_in = 1'b1;
        step();
        checks++;
        if (tarjeta !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tarjeta_pulse got=%0b busy=%0b want=1 1", tarjeta, busy);
        end
        step();
        checks++;
        if (tarjeta !== 1'b0) begin
            failures++;
            $display("FAIL tarjeta_single got=%0b want=0", tarjeta);
        end
        for (int i = 1; i <= 4; i++) begin
            press(4'(i));
            checks++;
            if (digito_stb !== 1'b1 || digito !== 4'(i)) begin
                failures++;
                $display("FAIL pin_digit%0d got=stb%0b d%0d want=1 %0d", i, digito_stb, digito, i);
            end
        end
        step();
        checks++;
        if (n_dig - d0 !== 4) begin
            failures++;
            $display("FAIL pin_count got=%0d want=4", n_dig - d0);
        end
    endtask

    // Continues from PIN_WAIT entered by test_card_and_pin (one wait cycle used).
    task automatic test_select_amount();
        step();
        step();
        press(4'hC);
        checks++;
        if (tipo !== 1'b0) begin
            failures++;
            $display("FAIL select_too_early got=%0b want=0", tipo);
        end
        press(4'hC);
        checks++;
        if (tipo !== 1'b1) begin
            failures++;
            $display("FAIL tipo_retiro got=%0b want=1", tipo);
        end
        press(4'd2); press(4'd5); press(4'd0); press(4'hA);
        checks++;
        if (monto_stb !== 1'b1 || monto !== 32'd250) begin
            failures++;
            $display("FAIL monto_250 got=stb%0b m%0d want=1 250", monto_stb, monto);
        end
        step();
        checks++;
        if (monto_stb !== 1'b0 || monto !== 32'd250) begin
            failures++;
            $display("FAIL monto_hold got=stb%0b m%0d want=0 250", monto_stb, monto);
        end
        bal = 1'b1;
        step();
        bal = 1'b0;
        press(4'hA);
        checks++;
        if (busy !== 1'b1 || monto_stb !== 1'b0) begin
            failures++;
            $display("FAIL done_wait got=busy%0b stb%0b want=1 0", busy, monto_stb);
        end
        card_in = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || monto !== '0 || tipo !== 1'b0) begin
            failures++;
            $display("FAIL done_to_idle got=busy%0b m%0d t%0b want=0 0 0", busy, monto, tipo);
        end
    endtask

    task automatic test_pin_retry();
        card_in = 1'b1;
        step();
        for (int i = 5; i <= 8; i++) press(4'(i));
        step();
        pin_inc = 1'b1;
        step();
        pin_inc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            press(4'(9 - i));
            checks++;
            if (digito_stb !== 1'b1 || digito !== 4'(9 - i)) begin
                failures++;
                $display("FAIL retry_digit%0d got=stb%0b d%0d want=1 %0d", i, digito_stb, digito, 9 - i);
            end
        end
        card_in = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL retry_card_out got=%0b want=0", busy);
        end
    endtask

    task automatic test_locked();
        int s0;
        card_in = 1'b1;
        step();
        for (int i = 0; i < 4; i++) press(4'd3);
        bloqueo = 1'b1;
        step();
        bloqueo = 1'b0;
        step();
        s0 = n_tar + n_dig + n_mon;
        press(4'd1); press(4'hC); press(4'hA);
        card_in = 1'b0; step();
        card_in = 1'b1; step();
        bal = 1'b1; step(); bal = 1'b0;
        press(4'd2);
        step();
        checks++;
        if ((n_tar + n_dig + n_mon) - s0 !== 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL locked_silent got=strobes%0d busy%0b want=0 1", (n_tar + n_dig + n_mon) - s0, busy);
        end
        reset = 1'b1;
        card_in = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || tipo !== 1'b0 || monto !== '0) begin
            failures++;
            $display("FAIL locked_reset got=busy%0b want=0", busy);
        end
    endtask

    task automatic test_amount_limits();
        go_to_amount(4'hD);
        repeat (10) press(4'd9);
        press(4'hA);
        checks++;
        if (monto_stb !== 1'b1 || monto !== 32'd999999999 || tipo !== 1'b0) begin
            failures++;
            $display("FAIL monto_max got=stb%0b m%0d t%0b want=1 999999999 0", monto_stb, monto, tipo);
        end
        end_session(1'b0);
        go_to_amount(4'hC);
        press(4'd4);
        press(4'hB);
        press(4'hA);
        checks++;
        if (monto_stb !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL enter_empty got=stb%0b want=0", monto_stb);
        end
        press(4'd7);
        press(4'hA);
        checks++;
        if (monto_stb !== 1'b1 || monto !== 32'd7) begin
            failures++;
            $display("FAIL monto_7 got=stb%0b m%0d want=1 7", monto_stb, monto);
        end
        end_session(1'b1);
    endtask

    task automatic test_reset_mid();
        go_to_amount(4'hC);
        press(4'd1);
        press(4'd2);
        reset = 1'b1;
        card_in = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if ({tarjeta, digito_stb, tipo, monto_stb, busy, digito, monto} !== '0) begin
            failures++;
            $display("FAIL reset_mid got=%0h want=0", {tarjeta, digito_stb, tipo, monto_stb, busy, digito, monto});
        end
        card_in = 1'b1;
        step();
        press(4'd3);
        key_valid = 1'b1;
        key_code = 4'd5;
        card_in = 1'b0;
        step();
        key_valid = 1'b0;
        checks++;
        if (digito_stb !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL card_out_mid_pin got=stb%0b busy%0b want=0 0", digito_stb, busy);
        end
    endtask

    task automatic test_random_sessions();
        logic [3:0] exp_pin[$];
        logic [3:0] k;
        longint     acc;
        int         nd, cnt, bad, m0;
        logic       exp_tipo;
        for (int s = 0; s < 12; s++) begin
            card_in = 1'b1;
            step();
            q_dig.delete();
            exp_pin.delete();
            cnt = 0;
            while (cnt < 4) begin
                if ($urandom_range(0, 3) == 0) begin
                    press(4'($urandom_range(10, 15)));
                end else begin
                    k = 4'($urandom_range(0, 9));
                    press(k);
                    exp_pin.push_back(k);
                    cnt++;
                end
                if (cnt < 4) repeat ($urandom_range(0, 2)) step();
            end
            repeat (4) step();
            bad = (q_dig.size() == 4) ? 0 : 1;
            for (int i = 0; i < 4 && i < q_dig.size(); i++) if (q_dig[i] !== exp_pin[i]) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rand_pin s%0d got=%0d digits bad=%0d want=4 bad=0", s, q_dig.size(), bad);
            end
            repeat ($urandom_range(0, 2)) begin
                k = 4'($urandom_range(0, 15));
                if (k == 4'hC || k == 4'hD) k = 4'hE;
                press(k);
            end
            exp_tipo = 1'($urandom_range(0, 1));
            press(exp_tipo ? 4'hC : 4'hD);
            acc = 0;
            nd = 0;
            repeat ($urandom_range(0, 14)) begin
                cnt = $urandom_range(0, 9);
                if (cnt < 7) begin
                    k = 4'($urandom_range(0, 9));
                    if (nd < 9) begin acc = acc * 10 + longint'(k); nd++; end
                end else if (cnt == 7) begin
                    k = 4'hB; acc = 0; nd = 0;
                end else begin
                    k = (cnt == 8) ? 4'hE : 4'hF;
                end
                press(k);
                if ($urandom_range(0, 3) == 0) step();
            end
            if (nd == 0) begin
                k = 4'($urandom_range(1, 9));
                press(k);
                acc = longint'(k);
            end
            m0 = n_mon;
            press(4'hA);
            checks++;
            if (monto_stb !== 1'b1 || monto !== AMT_W'(acc) || tipo !== exp_tipo) begin
                failures++;
                $display("FAIL rand_monto s%0d got=stb%0b m%0d t%0b want=1 %0d %0b", s, monto_stb, monto, tipo, acc, exp_tipo);
            end
            end_session(1'($urandom_range(0, 1)));
            checks++;
            if (busy !== 1'b0 || n_mon - m0 !== 1) begin
                failures++;
                $display("FAIL rand_end s%0d got=busy%0b nstb%0d want=0 1", s, busy, n_mon - m0);
            end
        end
    endtask

    initial begin
        reset = 1'b1; card_in = 1'b0; key_valid = 1'b0; key_code = 4'd0;
        pin_inc = 1'b0; bloqueo = 1'b0; bal = 1'b0; fondos = 1'b0;
        test_reset();
        test_card_and_pin();
        test_select_amount();
        test_pin_retry();
        test_locked();
        test_amount_limits();
        test_reset_mid();
        test_random_sessions();
        step();
        checks++;
        if (n_multi !== 0) begin
            failures++;
            $display("FAIL one_strobe_per_cycle got=%0d want=0", n_multi);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
